// File: rtl/irq_arb_pkg.sv
// Shared types and constants for the interrupt arbiter.
// IRQ_MAX_SRC bounds N_SRC; source ids are always 4 bits wide.
package irq_arb_pkg;

   localparam int          IRQ_MAX_SRC    = 16;
   localparam logic [31:0] IRQ_CAUSE_BASE = 32'h8000_0010;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      ACTIVE = 2'd2
   } irq_arb_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Find-first-set over the request vector, starting the search at i_offset and
// wrapping; an offset of 0 gives plain lowest-index priority.
module irq_prio_enc
   import irq_arb_pkg::*;
#(
   parameter int N_SRC = IRQ_MAX_SRC
) (
   input  logic [N_SRC-1:0] i_req,
   input  logic [3:0]       i_offset,
   output logic [3:0]       o_id,
   output logic             o_valid
);

   logic [2*N_SRC-1:0] w_dbl;
   logic [N_SRC-1:0]   w_rot;
   logic [4:0]         w_pos;
   logic [4:0]         w_sum;

   // Rotating a doubled copy puts the search start at bit 0.
   assign w_dbl = {i_req, i_req};
   assign w_rot = N_SRC'(w_dbl >> i_offset);

   always_comb begin
      w_pos = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_pos = 5'(i);
         end
      end
   end

   assign w_sum   = {1'b0, i_offset} + w_pos;
   assign o_id    = (w_sum >= 5'(N_SRC)) ? 4'(w_sum - 5'(N_SRC)) : w_sum[3:0];
   assign o_valid = |i_req;

endmodule

// File: rtl/irq_arbiter.sv
// Multi-source interrupt front end: edge capture, enable gating, arbitration and
// request/handler handshake. IRQ_ARB_ROUND_ROBIN_EN selects rotating priority.
module irq_arbiter
   import irq_arb_pkg::*;
#(
   parameter int          N_SRC      = IRQ_MAX_SRC,
   parameter logic [31:0] CAUSE_BASE = IRQ_CAUSE_BASE
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N_SRC-1:0] irq_src_i,
   input  logic [N_SRC-1:0] irq_en_i,
   input  logic             irq_ack_i,
   input  logic             irq_ret_i,
   output logic             irq_req_o,
   output logic [31:0]      irq_cause_o,
   output logic [3:0]       irq_id_o,
   output logic             irq_active_o,
   output logic [N_SRC-1:0] irq_pending_o
);

   irq_arb_state_t   r_state;
   irq_arb_state_t   w_nextState;
   logic [N_SRC-1:0] r_srcQ;
   logic [N_SRC-1:0] r_pending;
   logic [3:0]       r_selId;
   logic [N_SRC-1:0] w_edge;
   logic [N_SRC-1:0] w_cand;
   logic [N_SRC-1:0] w_selMask;
   logic [N_SRC-1:0] w_clr;
   logic [3:0]       w_winId;
   logic [3:0]       w_offset;
   logic             w_winValid;
   logic             w_selCand;
   logic             w_take;

   assign w_edge    = irq_src_i & ~r_srcQ;
   assign w_cand    = r_pending & irq_en_i;
   assign w_selMask = N_SRC'(1) << r_selId;
   assign w_selCand = |(w_cand & w_selMask);
   assign w_take    = (r_state == REQ) && irq_ack_i;
   assign w_clr     = w_take ? w_selMask : '0;

`ifdef IRQ_ARB_ROUND_ROBIN_EN
   logic [3:0] r_lastId;

   // Search resumes just past the most recently acknowledged source.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_lastId <= 4'(N_SRC - 1);
      end else if (w_take) begin
         r_lastId <= r_selId;
      end
   end

   assign w_offset = (r_lastId == 4'(N_SRC - 1)) ? 4'd0 : r_lastId + 4'd1;
`else
   assign w_offset = 4'd0;
`endif

   irq_prio_enc #(
      .N_SRC(N_SRC)
   ) u_enc (
      .i_req   (w_cand),
      .i_offset(w_offset),
      .o_id    (w_winId),
      .o_valid (w_winValid)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_winValid) begin
               w_nextState = REQ;
            end
         end
         REQ: begin
            if (irq_ack_i) begin
               w_nextState = ACTIVE;
            end else if (!w_selCand) begin
               w_nextState = IDLE;
            end
         end
         ACTIVE: begin
            if (irq_ret_i) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // A fresh edge outranks the ack-clear, so a re-fire during ack stays pending.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_srcQ    <= '0;
         r_pending <= '0;
         r_selId   <= '0;
      end else begin
         r_srcQ    <= irq_src_i;
         r_pending <= (r_pending & ~w_clr) | w_edge;
         if ((r_state == IDLE) && w_winValid) begin
            r_selId <= w_winId;
         end
      end
   end

   always_comb begin
      irq_req_o    = 1'b0;
      irq_active_o = 1'b0;
      irq_cause_o  = '0;
      irq_id_o     = '0;
      case (r_state)
         REQ: begin
            irq_req_o   = 1'b1;
            irq_cause_o = CAUSE_BASE + {28'd0, r_selId};
            irq_id_o    = r_selId;
         end
         ACTIVE: begin
            irq_active_o = 1'b1;
            irq_cause_o  = CAUSE_BASE + {28'd0, r_selId};
            irq_id_o     = r_selId;
         end
         default: ;
      endcase
   end

   assign irq_pending_o = r_pending;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed scenarios plus random traffic
// against a cycle-level reference model of the arbitration rules.
module tb_irq_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [15:0] irq_src_i;
   logic [15:0] irq_en_i;
   logic        irq_ack_i;
   logic        irq_ret_i;
   logic        irq_req_o;
   logic [31:0] irq_cause_o;
   logic [3:0]  irq_id_o;
   logic        irq_active_o;
   logic [15:0] irq_pending_o;

   int nCompared   = 0;
   int nMismatched = 0;

   logic [15:0] mPending;
   logic [15:0] mPrev;
   logic [3:0]  mSel;
   bit          mReq;
   bit          mActive;
`ifdef IRQ_ARB_ROUND_ROBIN_EN
   int          mLast;
`endif

   irq_arbiter dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .irq_src_i    (irq_src_i),
      .irq_en_i     (irq_en_i),
      .irq_ack_i    (irq_ack_i),
      .irq_ret_i    (irq_ret_i),
      .irq_req_o    (irq_req_o),
      .irq_cause_o  (irq_cause_o),
      .irq_id_o     (irq_id_o),
      .irq_active_o (irq_active_o),
      .irq_pending_o(irq_pending_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [3:0] pickWinner(input logic [15:0] cand, input int start);
      for (int i = 0; i < 16; i++) begin
         int k;
         k = (start + i) % 16;
         if (((cand >> k) & 16'd1) != 16'd0) return 4'(k);
      end
      return 4'd0;
   endfunction

   // Drive one cycle from the falling edge, advance the model at the rising edge,
   // and return on the next falling edge where outputs are stable.
   task automatic tick(input logic [15:0] src, input logic [15:0] en,
                       input logic ack, input logic ret, input logic rst);
      logic [15:0] edgeV;
      logic [15:0] cand;
      logic [15:0] clr;
      irq_src_i = src;
      irq_en_i  = en;
      irq_ack_i = ack;
      irq_ret_i = ret;
      rst_i     = rst;
      @(posedge clk_i);
      edgeV = src & ~mPrev;
      cand  = mPending & en;
      clr   = 16'd0;
      if (rst) begin
         mPending = 16'd0;
         mPrev    = 16'd0;
         mSel     = 4'd0;
         mReq     = 1'b0;
         mActive  = 1'b0;
`ifdef IRQ_ARB_ROUND_ROBIN_EN
         mLast    = 15;
`endif
      end else begin
         if (!mReq && !mActive) begin
            if (cand != 16'd0) begin
`ifdef IRQ_ARB_ROUND_ROBIN_EN
               mSel = pickWinner(cand, (mLast + 1) % 16);
`else
               mSel = pickWinner(cand, 0);
`endif
               mReq = 1'b1;
            end
         end else if (mReq) begin
            if (ack) begin
               clr     = 16'd1 << mSel;
               mReq    = 1'b0;
               mActive = 1'b1;
`ifdef IRQ_ARB_ROUND_ROBIN_EN
               mLast   = int'(mSel);
`endif
            end else if (((cand >> mSel) & 16'd1) == 16'd0) begin
               mReq = 1'b0;
            end
         end else if (ret) begin
            mActive = 1'b0;
         end
         mPending = (mPending & ~clr) | edgeV;
         mPrev    = src;
      end
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      tick(16'h0, 16'hFFFF, 1'b0, 1'b0, 1'b1);
      tick(16'h0, 16'hFFFF, 1'b0, 1'b0, 1'b1);
      nCompared++; if (irq_req_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_req got %b want 0", irq_req_o); end
      nCompared++; if (irq_active_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_active got %b want 0", irq_active_o); end
      nCompared++; if (irq_cause_o !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_cause got %h want 0", irq_cause_o); end
      nCompared++; if (irq_id_o !== 4'd0) begin nMismatched++; $display("[TB] FAIL reset_id got %h want 0", irq_id_o); end
      nCompared++; if (irq_pending_o !== 16'd0) begin nMismatched++; $display("[TB] FAIL reset_pending got %h want 0", irq_pending_o); end
      tick(16'h0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_single();
      tick(16'h0008, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      nCompared++; if (irq_pending_o !== 16'h0008) begin nMismatched++; $display("[TB] FAIL single_pending got %h want 0008", irq_pending_o); end
      nCompared++; if (irq_req_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_req_early got %b want 0", irq_req_o); end
      tick(16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      nCompared++; if (irq_req_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_req got %b want 1", irq_req_o); end
      nCompared++; if (irq_cause_o !== 32'h8000_0013) begin nMismatched++; $display("[TB] FAIL single_cause got %h want 80000013", irq_cause_o); end
      tick(16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      nCompared++; if (irq_active_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_active got %b want 1", irq_active_o); end
      nCompared++; if (irq_pending_o !== 16'h0000) begin nMismatched++; $display("[TB] FAIL single_clear got %h want 0000", irq_pending_o); end
      nCompared++; if (irq_id_o !== 4'd3) begin nMismatched++; $display("[TB] FAIL single_id got %h want 3", irq_id_o); end
      tick(16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0);
      nCompared++; if (irq_active_o !== 1'b0 || irq_cause_o !== 32'd0) begin nMismatched++; $display("[TB] FAIL single_ret got active=%b cause=%h want 0/0", irq_active_o, irq_cause_o); end
   endtask

   task automatic test_priority();
      tick(16'h0024, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      tick(16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      nCompared++; if (irq_cause_o !== 32'h8000_0012) begin nMismatched++; $display("[TB] FAIL prio_first got %h want 80000012", irq_cause_o); end
      tick(16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      nCompared++; if (irq_pending_o !== 16'h0020) begin nMismatched++; $display("[TB] FAIL prio_pending got %h want 0020", irq_pending_o); end
      tick(16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0);
      nCompared++; if (irq_req_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL prio_idle got %b want 0", irq_req_o); end
      tick(16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      nCompared++; if (irq_req_o !== 1'b1 || irq_cause_o !== 32'h8000_0015) begin nMismatched++; $display("[TB] FAIL prio_second got req=%b cause=%h want 1/80000015", irq_req_o, irq_cause_o); end
      tick(16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      tick(16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_withdraw();
      tick(16'h0080, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      tick(16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      nCompared++; if (irq_req_o !== 1'b1 || irq_id_o !== 4'd7) begin nMismatched++; $display("[TB] FAIL wd_req got req=%b id=%h want 1/7", irq_req_o, irq_id_o); end
      tick(16'h0000, 16'hFF7F, 1'b0, 1'b0, 1'b0);
      nCompared++; if (irq_req_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL wd_drop got %b want 0", irq_req_o); end
      nCompared++; if (irq_pending_o !== 16'h0080) begin nMismatched++; $display("[TB] FAIL wd_pending got %h want 0080", irq_pending_o); end
      tick(16'h0000, 16'hFF7F, 1'b0, 1'b0, 1'b0);
      nCompared++; if (irq_req_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL wd_stay got %b want 0", irq_req_o); end
      tick(16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      nCompared++; if (irq_req_o !== 1'b1 || irq_cause_o !== 32'h8000_0017) begin nMismatched++; $display("[TB] FAIL wd_return got req=%b cause=%h want 1/80000017", irq_req_o, irq_cause_o); end
      tick(16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      tick(16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_set_wins();
      tick(16'h0010, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      tick(16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      tick(16'h0010, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      nCompared++; if (irq_pending_o !== 16'h0010) begin nMismatched++; $display("[TB] FAIL setwin_pending got %h want 0010", irq_pending_o); end
      nCompared++; if (irq_active_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL setwin_active got %b want 1", irq_active_o); end
      tick(16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0);
      tick(16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      nCompared++; if (irq_req_o !== 1'b1 || irq_cause_o !== 32'h8000_0014) begin nMismatched++; $display("[TB] FAIL setwin_again got req=%b cause=%h want 1/80000014", irq_req_o, irq_cause_o); end
      tick(16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      tick(16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid();
      tick(16'h0002, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      tick(16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      tick(16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      nCompared++; if (irq_active_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL rstmid_active got %b want 1", irq_active_o); end
      tick(16'h0040, 16'hFFFF, 1'b0, 1'b0, 1'b1);
      nCompared++; if ({irq_req_o, irq_active_o, irq_cause_o, irq_id_o, irq_pending_o} !== 54'd0) begin nMismatched++; $display("[TB] FAIL rstmid_zero got req=%b act=%b cause=%h id=%h pend=%h want all 0", irq_req_o, irq_active_o, irq_cause_o, irq_id_o, irq_pending_o); end
      tick(16'h0040, 16'hFFFF, 1'b0, 1'b0, 1'b1);
      tick(16'h0040, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      nCompared++; if (irq_pending_o !== 16'h0040) begin nMismatched++; $display("[TB] FAIL rstmid_edge got %h want 0040", irq_pending_o); end
      tick(16'h0040, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      nCompared++; if (irq_req_o !== 1'b1 || irq_cause_o !== 32'h8000_0016) begin nMismatched++; $display("[TB] FAIL rstmid_req got req=%b cause=%h want 1/80000016", irq_req_o, irq_cause_o); end
      tick(16'h0040, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      tick(16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0);
   endtask

`ifdef IRQ_ARB_ROUND_ROBIN_EN
   task automatic test_round_robin();
      logic [15:0] reFire;
      tick(16'h0003, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      tick(16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         nCompared++; if (irq_req_o !== 1'b1 || irq_id_o !== 4'(k % 2)) begin nMismatched++; $display("[TB] FAIL rr_order got req=%b id=%h want 1/%0d", irq_req_o, irq_id_o, k % 2); end
         reFire = 16'd1 << (k % 2);
         tick(reFire, 16'hFFFF, 1'b1, 1'b0, 1'b0);
         tick(16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0);
         tick(16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      end
   endtask
`endif

   task automatic test_random();
      logic [31:0] expCause;
      logic [3:0]  expId;
      tick(16'h0, 16'hFFFF, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 600; c++) begin
         tick(16'($urandom) & 16'($urandom),
              ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF,
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 99) == 0));
         expCause = (mReq || mActive) ? 32'h8000_0010 + {28'd0, mSel} : 32'd0;
         expId    = (mReq || mActive) ? mSel : 4'd0;
         nCompared++; if (irq_req_o !== mReq) begin nMismatched++; $display("[TB] FAIL rnd_req cyc=%0d got %b want %b", c, irq_req_o, mReq); end
         nCompared++; if (irq_active_o !== mActive) begin nMismatched++; $display("[TB] FAIL rnd_active cyc=%0d got %b want %b", c, irq_active_o, mActive); end
         nCompared++; if (irq_cause_o !== expCause) begin nMismatched++; $display("[TB] FAIL rnd_cause cyc=%0d got %h want %h", c, irq_cause_o, expCause); end
         nCompared++; if (irq_id_o !== expId) begin nMismatched++; $display("[TB] FAIL rnd_id cyc=%0d got %h want %h", c, irq_id_o, expId); end
         nCompared++; if (irq_pending_o !== mPending) begin nMismatched++; $display("[TB] FAIL rnd_pending cyc=%0d got %h want %h", c, irq_pending_o, mPending); end
      end
   endtask

   initial begin
      rst_i     = 1'b1;
      irq_src_i = '0;
      irq_en_i  = '1;
      irq_ack_i = 1'b0;
      irq_ret_i = 1'b0;
      mPending  = '0;
      mPrev     = '0;
      mSel      = '0;
      mReq      = 1'b0;
      mActive   = 1'b0;
`ifdef IRQ_ARB_ROUND_ROBIN_EN
      mLast     = 15;
`endif
      @(negedge clk_i);
      test_reset();
      test_single();
      test_priority();
      test_withdraw();
      test_set_wins();
      test_reset_mid();
`ifdef IRQ_ARB_ROUND_ROBIN_EN
      test_round_robin();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Multi-source interrupt front end sitting in front of the single-line interrupt controller.
- Captures rising edges from up to 16 peripheral IRQ lines into a pending register and gates them with per-source enables.
- Picks one winner, presents it as a single request plus mcause-style code, and holds that selection until the core returns from the handler.
- Connects irq_req_o to the controller's irq_req_i, the controller's irq_o to irq_ack_i, and the controller's irq_ret_o to irq_ret_i.

Parameters:
- N_SRC, 16, number of interrupt sources; legal range 1..16.
- CAUSE_BASE, 32'h8000_0010, cause code reported for source 0; source k reports CAUSE_BASE + k.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; synchronous, active-high.
- irq_src_i  in  N_SRC  raw peripheral IRQ lines, already synchronous to clk_i.
- irq_en_i  in  N_SRC  per-source enable; 1 = may be selected.
- irq_ack_i  in  1  controller accepted the request (controller irq_o).
- irq_ret_i  in  1  handler finished (controller irq_ret_o).
- irq_req_o  out  1  request to controller.
- irq_cause_o  out  32  cause code of the selected source.
- irq_id_o  out  4  index of the selected or active source.
- irq_active_o  out  1  a handler is in progress.
- irq_pending_o  out  N_SRC  pending register, for CSR readback.

Behaviour:
- Edge capture:
  - src_q <= irq_src_i every cycle.
  - An edge is irq_src_i & ~src_q.
  - An edge sets pending[k] on the next clock.
  - pending[k] clears only on ack of source k.
  - If an edge on k and the clear of k land in the same cycle, the set wins and pending[k] stays 1.
- Candidates: pending & irq_en_i.
- Fixed priority: the lowest index wins.
- State machine IDLE / REQ / ACTIVE (2-bit state register):
  - IDLE:
    - irq_req_o = 0.
    - If any candidate exists, sel_id <= winner and go to REQ next cycle.
    - Latency from source edge to irq_req_o = 1 is 2 cycles.
  - REQ:
    - irq_req_o = 1; irq_cause_o = CAUSE_BASE + sel_id; sel_id is frozen.
    - If irq_ack_i: clear pending[sel_id] and go to ACTIVE.
    - Else if candidate[sel_id] == 0 (enable dropped): withdraw and go to IDLE. irq_req_o falls the next cycle and re-arbitration happens from IDLE.
    - A higher-priority source arriving in REQ does not preempt.
  - ACTIVE:
    - irq_req_o = 0; irq_active_o = 1; irq_id_o = sel_id.
    - irq_ack_i is ignored.
    - On irq_ret_i go to IDLE. If candidates remain, the next request is raised 1 cycle later (passes through IDLE).
  - irq_ret_i outside ACTIVE is ignored.
- Outputs:
  - irq_cause_o and irq_id_o are registered from sel_id and valid in REQ and ACTIVE.
  - irq_cause_o is 0 in IDLE.
- Edges keep being captured in every state, including during ACTIVE.
- Reset, including mid-handler:
  - state = IDLE, pending = 0, src_q = 0, sel_id = 0.
  - All outputs are 0.
  - A source held high through reset creates an edge on the first cycle after reset release.

Optional Feature:
- Macro: IRQ_ARB_ROUND_ROBIN_EN.
- Defined:
  - Rotating priority. A last_id register is updated on each ack.
  - The search starts at last_id+1 modulo N_SRC and wraps.
  - last_id resets to N_SRC-1, so the first search starts at 0.
- Undefined: fixed lowest-index priority; no last_id register.

Decomposition:
- Package irq_arb_pkg:
  - state enum irq_arb_state_t {IDLE, REQ, ACTIVE}.
  - Constants IRQ_MAX_SRC = 16 and IRQ_CAUSE_BASE = 32'h8000_0010.
- Sub-module irq_prio_enc:
  - Combinational find-first-set over N_SRC bits with a start-offset input (offset tied to 0 without the macro).
  - Outputs a 4-bit id and a valid bit.

Test Plan:
- Single source: pulse irq_src_i[3] with en = 16'hFFFF → irq_req_o = 1 two cycles later, cause = 32'h8000_0013. Ack → irq_active_o = 1 and pending[3] = 0. irq_ret_i → IDLE.
- Priority: edges on sources 5 and 2 in the same cycle → cause 0x8000_0012 first. After ret, 0x8000_0015 is requested 1 cycle after IDLE.
- Withdrawal: in REQ for source 7, deassert irq_en_i[7] → irq_req_o = 0 the next cycle, pending[7] stays 1. Re-enable → request reappears.
- Set-wins: new edge on source 4 in the same cycle as its ack → pending[4] = 1 afterwards. A second request for source 4 follows ret.
- Reset mid-ACTIVE: assert rst_i while irq_active_o = 1 → all outputs 0 the next cycle. Source held high through reset → request after release.
- Round-robin (macro on): sources 0 and 1 held pending continuously → acks alternate 0, 1, 0, 1.
